// File: rtl/rx_dec_pkg.sv
// Shared constants, coefficient table and output rounding for the Rx decimate-by-4 FIR.
package rx_dec_pkg;

  localparam int unsigned DEC_FACTOR   = 4;
  localparam int unsigned NTAPS        = 16;
  localparam int unsigned BRANCH_TAPS  = NTAPS / DEC_FACTOR;
  localparam int unsigned PH_W         = $clog2(DEC_FACTOR);
  localparam int unsigned ACC_W_C      = 25;
  localparam int unsigned OUT_W_C      = 12;

  localparam int signed COEF [NTAPS] = '{
    1, 35, 161, 315, 512, 680, 800, 860,
    860, 800, 680, 512, 315, 161, 35, 1
  };

  localparam logic signed [ACC_W_C-1:0] OUT_MAX = ACC_W_C'((2 ** (OUT_W_C - 1)) - 1);
  localparam logic signed [ACC_W_C-1:0] OUT_MIN = ACC_W_C'(-(2 ** (OUT_W_C - 1)));

  // Round half up, arithmetic shift, then clamp to the signed output range.
  function automatic logic signed [OUT_W_C-1:0] sat_round(
    input logic signed [ACC_W_C-1:0] acc,
    input int unsigned               shift
  );
    logic signed [ACC_W_C-1:0] rnd;
    logic signed [ACC_W_C-1:0] r;
    rnd = ACC_W_C'(1) <<< (shift - 1);
    r   = (acc + rnd) >>> shift;
    if (r > OUT_MAX) begin
      return OUT_W_C'(OUT_MAX);
    end else if (r < OUT_MIN) begin
      return OUT_W_C'(OUT_MIN);
    end
    return OUT_W_C'(r);
  endfunction

endpackage

// File: rtl/rx_poly_branch.sv
// One polyphase branch: 4-tap multiply-add on taps p, p+4, p+8, p+12, registered on enable.
module rx_poly_branch
  import rx_dec_pkg::*;
#(
  parameter int unsigned P     = 0,
  parameter int unsigned IN_W  = 12,
  parameter int unsigned ACC_W = 25
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic signed [IN_W-1:0]  taps_i [BRANCH_TAPS],
  output logic signed [ACC_W-1:0] sum_o
);

  logic signed [ACC_W-1:0] sum_d;
  logic signed [ACC_W-1:0] sum_q;

  always_comb begin
    sum_d = '0;
    for (int j = 0; j < BRANCH_TAPS; j++) begin
      sum_d = sum_d + ACC_W'(taps_i[j]) * ACC_W'(COEF[DEC_FACTOR * j + P]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (en_i) begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/rx_decimation_filter.sv
// Decimate-by-4, 16-tap symmetric low-pass FIR; two-stage valid-tagged pipeline after
// each decimation point, one rounded/saturated output per four accepted samples.
module rx_decimation_filter
  import rx_dec_pkg::*;
#(
  parameter int unsigned IN_W  = 12,
  parameter int unsigned ACC_W = 25,
  parameter int unsigned OUT_W = 12,
  parameter int unsigned SHIFT = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_dec,
  input  logic                    sync,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_dec
);

  logic signed [IN_W-1:0]  xd_q [NTAPS];
  logic signed [IN_W-1:0]  xd_d [NTAPS];
  logic [PH_W-1:0]         ph_q, ph_d, ph_eff;
  logic                    dec_q, dec_d;
  logic                    v1_q;
  logic                    out_valid_q;
  logic signed [OUT_W-1:0] out_dec_q, out_dec_d;
  logic signed [ACC_W-1:0] bsum [DEC_FACTOR];
  logic signed [ACC_W-1:0] acc_c;

  // Delay-line shift and phase tracking; sync realigns the incoming sample to phase 0.
  always_comb begin
    for (int i = 0; i < NTAPS; i++) begin
      xd_d[i] = xd_q[i];
    end
    dec_d  = 1'b0;
    ph_eff = sync ? '0 : ph_q;
    ph_d   = ph_eff;
    if (in_valid) begin
      xd_d[0] = in_dec;
      for (int i = 1; i < NTAPS; i++) begin
        xd_d[i] = xd_q[i-1];
      end
      ph_d  = ph_eff + PH_W'(1);
      dec_d = (ph_eff == PH_W'(DEC_FACTOR - 1));
    end
  end

  for (genvar p = 0; p < DEC_FACTOR; p++) begin : g_branch
    logic signed [IN_W-1:0] taps [BRANCH_TAPS];
    for (genvar j = 0; j < BRANCH_TAPS; j++) begin : g_tap
      assign taps[j] = xd_q[DEC_FACTOR * j + p];
    end
    rx_poly_branch #(
      .P     (p),
      .IN_W  (IN_W),
      .ACC_W (ACC_W)
    ) u_branch (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (dec_q),
      .taps_i (taps),
      .sum_o  (bsum[p])
    );
  end

  always_comb begin
    acc_c = '0;
    for (int p = 0; p < DEC_FACTOR; p++) begin
      acc_c = acc_c + bsum[p];
    end
    out_dec_d = sat_round(acc_c, SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) begin
        xd_q[i] <= '0;
      end
      ph_q        <= '0;
      dec_q       <= 1'b0;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_dec_q   <= '0;
    end else begin
      xd_q        <= xd_d;
      ph_q        <= ph_d;
      dec_q       <= dec_d;
      v1_q        <= dec_q;
      out_valid_q <= v1_q;
      if (v1_q) begin
        out_dec_q <= out_dec_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_dec   = out_dec_q;

endmodule

// File: tb/tb_rx_decimation_filter.sv
// Scoreboard bench for rx_decimation_filter: driver pushes expected value and arrival cycle,
// a negedge monitor pops and compares on every out_valid pulse.
module tb_rx_decimation_filter;

  localparam int H [16] = '{1, 35, 161, 315, 512, 680, 800, 860,
                            860, 800, 680, 512, 315, 161, 35, 1};

  typedef struct {
    int     val;
    longint cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [11:0] in_dec = '0;
  logic               sync = 1'b0;
  logic               out_valid;
  logic signed [11:0] out_dec;

  longint cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;
  exp_t   exp_q [$];
  int     hand_q [$];
  int     hist [16];
  int     mph = 0;
  exp_t   mon_e;

  rx_decimation_filter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_dec    (in_dec),
    .sync      (sync),
    .out_valid (out_valid),
    .out_dec   (out_dec)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ref_out();
    longint acc = 0;
    longint r;
    for (int k = 0; k < 16; k++) acc += longint'(H[k]) * longint'(hist[k]);
    r = (acc + 2048) >>> 12;
    if (r > 2047) r = 2047;
    if (r < -2048) r = -2048;
    return int'(r);
  endfunction

  task automatic model_clear();
    exp_q.delete();
    hand_q.delete();
    for (int k = 0; k < 16; k++) hist[k] = 0;
    mph = 0;
  endtask

  task automatic send(input bit v, input int x, input bit s);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    in_dec   = 12'(x);
    sync     = s;
    @(posedge clk);
    #1;
    if (v) begin
      if (s) mph = 0;
      for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = x;
      if (mph == 3) begin
        e.val = (hand_q.size() != 0) ? hand_q.pop_front() : ref_out();
        e.cyc = cyc + 2;
        exp_q.push_back(e);
      end
      mph = (mph + 1) % 4;
    end
    in_valid = 1'b0;
    sync     = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 0, 1'b0);
  endtask

  // Monitor: every pulse must match the oldest expected value and arrive on its cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse cyc=%0d out_dec=%0d required no pulse", cyc, out_dec);
      end else begin
        mon_e = exp_q.pop_front();
        n_cmp++;
        if (int'(out_dec) != mon_e.val) begin
          n_bad++;
          $display("FAIL out_dec cyc=%0d got %0d required %0d", cyc, out_dec, mon_e.val);
        end
        n_cmp++;
        if (cyc != mon_e.cyc) begin
          n_bad++;
          $display("FAIL latency got cyc %0d required cyc %0d", cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    bit v;
    model_clear();
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
    n_cmp++;
    if (out_dec !== 12'sd0) begin n_bad++; $display("FAIL reset_out_dec got %0d required 0", out_dec); end

    // Positive impulse, continuous input.
    do_reset();
    hand_q = '{157, 430, 256, 0, 0};
    for (int i = 0; i < 20; i++) send(1'b1, (i == 0) ? 2047 : 0, 1'b0);
    idle(4);

    // Negative impulse.
    do_reset();
    hand_q = '{-157, -430, -256, 0};
    for (int i = 0; i < 16; i++) send(1'b1, (i == 0) ? -2048 : 0, 1'b0);
    idle(4);

    // DC inputs: saturation at both rails and an in-range level.
    do_reset();
    for (int i = 0; i < 24; i++) send(1'b1, 2047, 1'b0);
    idle(4);
    do_reset();
    for (int i = 0; i < 24; i++) send(1'b1, -2048, 1'b0);
    idle(4);
    do_reset();
    hand_q = '{13, 82, 152, 164, 164};
    for (int i = 0; i < 20; i++) send(1'b1, 100, 1'b0);
    idle(4);

    // Gapped impulse: same values, latency measured from each 4th accepted sample.
    do_reset();
    hand_q = '{157, 430, 256, 0, 0};
    k = 0;
    while (k < 20) begin
      v = ($urandom_range(0, 3) != 0);
      send(v, (v && k == 0) ? 2047 : 0, 1'b0);
      if (v) k++;
    end
    idle(4);

    // Reset mid-stream with a decimation point in flight.
    do_reset();
    for (int i = 0; i < 8; i++) send(1'b1, 500, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_out_valid got %b required 0", out_valid); end
    n_cmp++;
    if (out_dec !== 12'sd0) begin n_bad++; $display("FAIL midreset_out_dec got %0d required 0", out_dec); end
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    for (int i = 0; i < 3; i++) send(1'b1, 500, 1'b0);
    idle(5);
    hand_q = '{63};
    send(1'b1, 500, 1'b0);
    idle(4);

    // sync on the 2nd sample of a group: it becomes phase 0, delay line kept.
    do_reset();
    for (int i = 0; i < 16; i++) send(1'b1, i * 53 - 400, 1'b0);
    send(1'b1, 111, 1'b0);
    send(1'b1, -222, 1'b1);
    send(1'b1, 333, 1'b0);
    send(1'b1, -444, 1'b0);
    idle(2);
    send(1'b1, 555, 1'b0);
    idle(5);

    repeat (6) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_pulses got %0d outstanding required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
